// File: rtl/param_shift_register.sv
// Width-parametrised shift register that performs load, clear, shifts and rotates behind a start/done handshake.
// Multi-bit shifts advance one bit per clock under a down-counter, and abort can cancel them.
module param_shift_register #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] shamt,
    input  logic [WIDTH-1:0] pIn,
    input  logic             sInL,
    input  logic             sInR,
    output logic [WIDTH-1:0] pOut,
    output logic             sOutL,
    output logic             sOutR,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one shift per edge until the counter expires
    // DONE  | single-cycle completion pulse
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] M_LOAD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_ROL  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ASR  = 3'b101;
    localparam logic [2:0] M_CLR  = 3'b110;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data, data_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       mode_q, mode_nxt;

    function automatic logic [WIDTH-1:0] shift_one(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] v,
        input logic             fill_l,
        input logic             fill_r
    );
        logic [WIDTH-1:0] r;
        r = v;
        case (m)
            M_SHL:   r = {v[WIDTH-2:0], fill_r};
            M_SHR:   r = {fill_l, v[WIDTH-1:1]};
            M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
            M_ROR:   r = {v[0], v[WIDTH-1:1]};
            M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            data   <= '0;
            cnt    <= '0;
            mode_q <= M_LOAD;
        end else begin
            state  <= state_nxt;
            data   <= data_nxt;
            cnt    <= cnt_nxt;
            mode_q <= mode_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data;
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        case (state)
            IDLE: begin
                if (start) begin
                    case (mode)
                        M_LOAD: begin
                            data_nxt  = pIn;
                            state_nxt = DONE;
                        end
                        M_CLR: begin
                            data_nxt  = '0;
                            state_nxt = DONE;
                        end
                        M_SHL, M_SHR, M_ROL, M_ROR, M_ASR: begin
                            if (shamt == '0) begin
                                state_nxt = DONE;
                            end else begin
                                mode_nxt  = mode;
                                // Anything beyond a full width is redundant; clamp so rotates come back home.
                                cnt_nxt   = (shamt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shamt;
                                state_nxt = RUN;
                            end
                        end
                        default: state_nxt = DONE;
                    endcase
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    data_nxt = shift_one(mode_q, data, sInL, sInR);
                    cnt_nxt  = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign pOut  = data;
    assign sOutL = data[WIDTH-1];
    assign sOutR = data[0];
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_param_shift_register.sv
// Directed bench for param_shift_register (WIDTH=8), built around a scoreboard.
// The stimulus queues the per-cycle outputs it expects, and a negedge monitor pops and compares them.
module tb_param_shift_register;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] LOAD = 3'b000;
    localparam logic [2:0] SHL  = 3'b001;
    localparam logic [2:0] SHR  = 3'b010;
    localparam logic [2:0] ROL  = 3'b011;
    localparam logic [2:0] ROR  = 3'b100;
    localparam logic [2:0] ASR  = 3'b101;
    localparam logic [2:0] CLR  = 3'b110;
    localparam logic [2:0] NOP  = 3'b111;

    logic             clk = 1'b0;
    logic             rst, start, abort, sInL, sInR;
    logic [2:0]       mode;
    logic [CNT_W-1:0] shamt;
    logic [WIDTH-1:0] pIn, pOut;
    logic             sOutL, sOutR, busy, done;

    param_shift_register #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .shamt(shamt), .pIn(pIn), .sInL(sInL), .sInR(sInR), .pOut(pOut),
        .sOutL(sOutL), .sOutR(sOutR), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] p;
        logic       b;
        logic       d;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Each entry names the edge count after which its values must hold.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL stale_entry cyc=%0d missed at cyc=%0d", e.cyc, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            n_checks++;
            if (pOut !== e.p || busy !== e.b || done !== e.d ||
                sOutL !== e.p[7] || sOutR !== e.p[0]) begin
                n_fail++;
                $display("FAIL cyc%0d got pOut=%h busy=%b done=%b sOutL=%b sOutR=%b want pOut=%h busy=%b done=%b",
                         cyc, pOut, busy, done, sOutL, sOutR, e.p, e.b, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic want(input int k, input logic [7:0] p, input logic b, input logic d);
        exp_t x;
        x.cyc = cyc + k;
        x.p   = p;
        x.b   = b;
        x.d   = d;
        q.push_back(x);
    endtask

    task automatic issue(input logic [2:0] m, input logic [CNT_W-1:0] s, input logic [7:0] d);
        start = 1'b1;
        mode  = m;
        shamt = s;
        pIn   = d;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; sInL = 1'b0; sInR = 1'b0;
        mode = LOAD; shamt = '0; pIn = '0;
        tick();
        tick();

        // reset wins over start
        start = 1'b1; mode = LOAD; pIn = 8'hFF;
        want(0, 8'h00, 0, 0);
        want(1, 8'h00, 0, 0);
        tick();
        rst = 1'b1; start = 1'b0;
        tick();

        // load
        want(1, 8'hA5, 0, 1); want(2, 8'hA5, 0, 0);
        issue(LOAD, 0, 8'hA5); tick();

        // SHL 3 with fill 1, start ignored in RUN and DONE
        sInR = 1'b1;
        want(1, 8'hA5, 1, 0); want(2, 8'h4B, 1, 0); want(3, 8'h97, 1, 0);
        want(4, 8'h2F, 0, 1); want(5, 8'h2F, 0, 0);
        issue(SHL, 3, 8'h00);
        tick();
        start = 1'b1; mode = LOAD; pIn = 8'h00;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0; sInR = 1'b0;

        // ASR 2
        want(1, 8'h96, 0, 1); want(2, 8'h96, 0, 0);
        issue(LOAD, 0, 8'h96); tick();
        want(1, 8'h96, 1, 0); want(2, 8'hCB, 1, 0); want(3, 8'hE5, 0, 1); want(4, 8'hE5, 0, 0);
        issue(ASR, 2, 8'h00); repeat (3) tick();

        // ROR 9 clamps to 8; inputs changed after accept
        want(1, 8'h3C, 0, 1); want(2, 8'h3C, 0, 0);
        issue(LOAD, 0, 8'h3C); tick();
        want(1, 8'h3C, 1, 0); want(2, 8'h1E, 1, 0); want(3, 8'h0F, 1, 0); want(4, 8'h87, 1, 0);
        want(5, 8'hC3, 1, 0); want(6, 8'hE1, 1, 0); want(7, 8'hF0, 1, 0); want(8, 8'h78, 1, 0);
        want(9, 8'h3C, 0, 1); want(10, 8'h3C, 0, 0);
        issue(ROR, 9, 8'h00);
        mode = SHL; shamt = 1; pIn = 8'hFF;
        repeat (9) tick();

        // abort in IDLE/DONE is ignored
        want(1, 8'h81, 0, 1); want(2, 8'h81, 0, 0);
        abort = 1'b1;
        issue(LOAD, 0, 8'h81); tick();
        abort = 1'b0;

        // ROL 5 aborted at the third RUN edge
        want(1, 8'h81, 1, 0); want(2, 8'h03, 1, 0); want(3, 8'h06, 1, 0); want(4, 8'h06, 0, 0);
        issue(ROL, 5, 8'h00);
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        want(1, 8'h5A, 0, 1); want(2, 8'h5A, 0, 0);
        issue(LOAD, 0, 8'h5A); tick();

        // SHR 2 with fill 1
        want(1, 8'h81, 0, 1); want(2, 8'h81, 0, 0);
        issue(LOAD, 0, 8'h81); tick();
        sInL = 1'b1;
        want(1, 8'h81, 1, 0); want(2, 8'hC0, 1, 0); want(3, 8'hE0, 0, 1); want(4, 8'hE0, 0, 0);
        issue(SHR, 2, 8'h00); repeat (3) tick();
        sInL = 1'b0;

        // reset in the middle of RUN
        want(1, 8'hF0, 0, 1); want(2, 8'hF0, 0, 0);
        issue(LOAD, 0, 8'hF0); tick();
        want(1, 8'hF0, 1, 0); want(2, 8'h78, 1, 0); want(3, 8'h00, 0, 0); want(4, 8'h00, 0, 0);
        issue(SHR, 4, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // zero-count shift only pulses done
        sInR = 1'b1;
        want(1, 8'h00, 0, 1); want(2, 8'h00, 0, 0);
        issue(SHL, 0, 8'hFF); tick();
        sInR = 1'b0;

        // NOP then CLR
        want(1, 8'hC3, 0, 1); want(2, 8'hC3, 0, 0);
        issue(LOAD, 0, 8'hC3); tick();
        want(1, 8'hC3, 0, 1); want(2, 8'hC3, 0, 0);
        issue(NOP, 5, 8'hFF); tick();
        want(1, 8'h00, 0, 1); want(2, 8'h00, 0, 0);
        issue(CLR, 0, 8'hFF); tick();

        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout pending=%0d want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
